clk_div_detector: RTL and testbench

Recovers the 4-bit division code from a clock produced by `clk_divider` (period 2^div of `clk_in`). It measures the period of the incoming divided clock in `clk_in` cycles, checks that the period is an exact power of two and is stable, and reports the code with a lock flag. It sits on the return path from the I2S/codec clocking so the FX2LP-side control logic can confirm the active divide setting.

---
 rtl/clk_div_detector.sv | 153 +++++++++++++++
 tb/tb_clk_div_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_detector.sv
// Recovers the clk_divider code k from a divided clock of period 2^k clk_in cycles.
// Reports the code with a lock flag once the period has been stable for STABLE_N periods.
module clk_div_detector #(
  parameter int MAX_DIV  = 10,
  parameter int STABLE_N = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_meas,
  output logic [3:0] div_out,
  output logic       locked,
  output logic       div_chg
);

  localparam int CW = MAX_DIV + 1;
  localparam logic [CW-1:0] ONE_CNT     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TIMEOUT_CNT = (ONE_CNT << MAX_DIV) + ONE_CNT;

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

  // Returns {valid, k} where valid means p is exactly 2^k with 1 <= k <= MAX_DIV.
  function automatic logic [4:0] period_code(input logic [CW-1:0] p);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 1; i <= MAX_DIV; i++) begin
      if (p == (ONE_CNT << i)) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

  logic          s1_r, s2_r, s3_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    cand_r, match_r, div_out_r;
  logic          locked_r, div_chg_r;
  state_t        state_r;

  logic          rise_s, p_valid_s, timeout_s;
  logic [3:0]    p_k_s;
  logic [4:0]    match_inc_s;

  // Edge detect, period decode and timeout detection.
  always_comb begin
    rise_s                = s2_r & ~s3_r;
    {p_valid_s, p_k_s}    = period_code(cnt_r);
    match_inc_s           = {1'b0, match_r} + 5'd1;
    if ((state_r != IDLE) && (cnt_r == TIMEOUT_CNT) && !rise_s) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Two-flop synchronizer plus one stage for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= clk_meas;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Period counter and lock state machine; all outputs registered here.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      cand_r    <= 4'd0;
      match_r   <= 4'd0;
      div_out_r <= 4'd0;
      locked_r  <= 1'b0;
      div_chg_r <= 1'b0;
    end else begin
      div_chg_r <= 1'b0;
      if (rise_s) begin
        cnt_r <= ONE_CNT;
        case (state_r)
          IDLE: begin
            state_r <= MEASURE;
          end
          MEASURE: begin
            if (p_valid_s) begin
              cand_r  <= p_k_s;
              match_r <= 4'd1;
              if (STABLE_N == 1) begin
                div_out_r <= p_k_s;
                locked_r  <= 1'b1;
                div_chg_r <= 1'b1;
                state_r   <= LOCKED;
              end else begin
                state_r <= TRACK;
              end
            end else begin
              state_r <= MEASURE;
            end
          end
          TRACK: begin
            if (!p_valid_s) begin
              state_r <= MEASURE;
            end else if (p_k_s == cand_r) begin
              match_r <= match_inc_s[3:0];
              if (match_inc_s == 5'(STABLE_N)) begin
                div_out_r <= cand_r;
                locked_r  <= 1'b1;
                div_chg_r <= 1'b1;
                state_r   <= LOCKED;
              end else begin
                state_r <= TRACK;
              end
            end else begin
              cand_r  <= p_k_s;
              match_r <= 4'd1;
            end
          end
          LOCKED: begin
            if (!p_valid_s) begin
              locked_r <= 1'b0;
              state_r  <= MEASURE;
            end else if (p_k_s != div_out_r) begin
              locked_r <= 1'b0;
              cand_r   <= p_k_s;
              match_r  <= 4'd1;
              state_r  <= TRACK;
            end else begin
              state_r <= LOCKED;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end else if (timeout_s) begin
        state_r  <= IDLE;
        locked_r <= 1'b0;
        cnt_r    <= '0;
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + ONE_CNT;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign div_out = div_out_r;
  assign locked  = locked_r;
  assign div_chg = div_chg_r;

endmodule

// File: tb/tb_clk_div_detector.sv
// Bench for clk_div_detector: period-level reference model compared every cycle,
// plus literal checkpoints after each directed phase.
module tb_clk_div_detector;

  localparam int MAX_DIV  = 10;
  localparam int STABLE_N = 4;
  localparam int TMO      = (1 << MAX_DIV) + 1;

  logic       clk_in   = 1'b0;
  logic       rst      = 1'b1;
  logic       clk_meas = 1'b0;
  logic [3:0] div_out;
  logic       locked;
  logic       div_chg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  clk_div_detector #(.MAX_DIV(MAX_DIV), .STABLE_N(STABLE_N)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .clk_meas(clk_meas),
    .div_out (div_out),
    .locked  (locked),
    .div_chg (div_chg)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: history of sampled clk_meas, rise times, run of equal valid periods.
  bit q[$];
  int cyc = 0, t_last = 0, m_div = 0, run = 0, run_k = 0;
  bit active = 1'b0, m_locked = 1'b0, m_chg = 1'b0;

  function automatic int period_k(input int p);
    if (p >= 2 && p <= (1 << MAX_DIV) && (p & (p - 1)) == 0) return $clog2(p);
    return -1;
  endfunction

  task automatic model_reset();
    q = '{1'b0, 1'b0, 1'b0, 1'b0};
    active   = 1'b0;
    m_locked = 1'b0;
    m_chg    = 1'b0;
    m_div    = 0;
    run      = 0;
  endtask

  task automatic model_step();
    bit r;
    int k;
    r = q[2] & ~q[1];
    q.push_back(clk_meas);
    q.delete(0);
    m_chg = 1'b0;
    cyc++;
    if (r) begin
      if (!active) begin
        active = 1'b1;
        run    = 0;
      end else begin
        k = period_k(cyc - t_last);
        if (k < 0) begin
          m_locked = 1'b0;
          run      = 0;
        end else if (m_locked) begin
          if (k != m_div) begin
            m_locked = 1'b0;
            run      = 1;
            run_k    = k;
          end
        end else begin
          if (run > 0 && k == run_k) run++;
          else begin
            run   = 1;
            run_k = k;
          end
          if (run == STABLE_N) begin
            m_locked = 1'b1;
            m_div    = k;
            m_chg    = 1'b1;
          end
        end
      end
      t_last = cyc;
    end else if (active && (cyc - t_last) == TMO) begin
      active   = 1'b0;
      m_locked = 1'b0;
      run      = 0;
    end
  endtask

  // Per-cycle comparison against the model, 1 time unit after the active edge.
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      #1;
      model_step();
      checks++;
      if ({div_out, locked, div_chg} !== {4'(m_div), m_locked, m_chg}) begin
        errors++;
        $display("FAIL model cycle %0d: div_out=%0d locked=%0b div_chg=%0b expected div_out=%0d locked=%0b div_chg=%0b",
                 cyc, div_out, locked, div_chg, m_div, m_locked, m_chg);
      end
      if (div_chg === 1'b1) pulses++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic gen(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < per; j++) begin
        @(negedge clk_in);
        clk_meas = (j < (per + 1) / 2);
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      clk_meas = v;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_div_out", div_out, 0);
    check("reset_locked", locked, 0);
    check("reset_div_chg", div_chg, 0);
    rst = 1'b0;
    hold(1'b0, 4);

    gen(8, 6);
    check("div3_div_out", div_out, 3);
    check("div3_locked", locked, 1);
    check("div3_pulses", pulses, 1);

    gen(4, 6);
    check("div2_div_out", div_out, 2);
    check("div2_locked", locked, 1);
    check("div2_pulses", pulses, 2);

    gen(6, 8);
    check("p6_locked", locked, 0);
    check("p6_div_out", div_out, 2);
    for (int i = 0; i < 4; i++) begin
      gen(8, 1);
      gen(4, 1);
    end
    check("alt_locked", locked, 0);
    check("alt_pulses", pulses, 2);

    gen(8, 6);
    check("relock3_div_out", div_out, 3);
    check("relock3_pulses", pulses, 3);

    hold(1'b0, 1100);
    check("stop_locked", locked, 0);
    check("stop_div_out", div_out, 3);
    gen(8, 4);
    check("restart_4rises_locked", locked, 0);
    gen(8, 2);
    check("restart_locked", locked, 1);
    check("restart_pulses", pulses, 4);

    gen(2, 8);
    check("p2_div_out", div_out, 1);
    check("p2_locked", locked, 1);
    gen(1024, 6);
    check("p1024_div_out", div_out, 10);
    check("p1024_locked", locked, 1);
    check("p1024_pulses", pulses, 6);
    gen(2048, 4);
    check("p2048_locked", locked, 0);
    check("p2048_div_out", div_out, 10);
    hold(1'b1, 1200);
    check("const_high_locked", locked, 0);
    check("const_high_pulses", pulses, 6);

    hold(1'b0, 4);
    gen(8, 6);
    check("prerst_locked", locked, 1);
    check("prerst_pulses", pulses, 7);
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("async_rst_div_out", div_out, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_div_chg", div_chg, 0);
    @(negedge clk_in);
    rst = 1'b0;
    gen(8, 6);
    check("postrst_div_out", div_out, 3);
    check("postrst_locked", locked, 1);
    check("postrst_pulses", pulses, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
